uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning core clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  core clock; one clock domain, all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ser_rx_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rd_valid_o  output  1  FIFO non-empty; rd_data_o valid.
REQ-008 SHALL have port rd_data_o  output  8  oldest received byte.
REQ-009 SHALL have port rd_ready_i  input  1  consumer accepts byte when rd_valid_o & rd_ready_i.
REQ-010 SHALL have port frame_err_o  output  1  sticky: stop bit sampled low.
REQ-011 SHALL have port overrun_o  output  1  sticky: byte dropped because FIFO full.
REQ-012 SHALL have port clr_err_i  input  1  single-cycle pulse clearing both sticky flags.

Function
REQ-013 SHALL pass ser_rx_i through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-014 SHALL use bit period DIV = CLK_FREQ/BAUDRATE (integer truncation) and half period DIV/2.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: on synchronized falling edge (prev 1, now 1->0), load counter with DIV/2 and go to START.
REQ-017 START: at counter expiry, line 0 -> load DIV, bit index 0, go DATA; line 1 -> glitch, return IDLE, nothing pushed.
REQ-018 DATA: each DIV expiry samples one bit LSB first into shift register; after bit 7, load DIV and go STOP.
REQ-019 STOP: at DIV expiry, line 1 -> push byte to FIFO (or set overrun_o if full), go IDLE; line 0 -> discard byte, set frame_err_o, go IDLE.
REQ-020 After a frame error SHALL not restart until line has been seen high then falls (REQ-016 edge rule).
REQ-021 Pushed byte SHALL appear on rd_valid_o/rd_data_o the cycle after the stop-bit sample cycle.
REQ-022 FIFO SHALL be first-word-fall-through; pop on rd_valid_o & rd_ready_i, rd_data_o stable while rd_valid_o & !rd_ready_i.
REQ-023 Simultaneous push and pop when full SHALL accept the push and drop nothing; overrun_o not set.
REQ-024 Simultaneous push and pop when empty SHALL not pop (rd_valid_o was 0); byte stored.
REQ-025 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping naturally; full = MSBs differ, lower bits equal.
REQ-026 Sticky flag set and clr_err_i in same cycle: set SHALL win.
REQ-027 rd_ready_i with rd_valid_o=0 SHALL have no effect.

Reset
REQ-028 On rst_ni low SHALL immediately: state IDLE, counters 0, synchronizer 1, FIFO empty, rd_valid_o 0, rd_data_o 0, frame_err_o 0, overrun_o 0.
REQ-029 Reset mid-frame SHALL discard the partial byte; after release, reception resumes only on next falling edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum type and a DIV-computation function shared with the transmitter.
REQ-031 FIFO SHALL be a sub-module uart_fifo (parameters WIDTH, DEPTH; push/pop/full/empty); receiver FSM in uart_rx_fifo.

Verification (CLK_FREQ=25_000_000, BAUDRATE=115200, DIV=217, 40 ns clock)
REQ-032 Send 0x68 ('h'), 8N1 at 8680 ns/bit -> rd_valid_o rises once, rd_data_o=0x68, both flags 0.
REQ-033 Send 0x00, 0xFF, 0xA5, 0x5A, 0x3C back-to-back with rd_ready_i=0 -> first four read in order, overrun_o=1 after fifth stop bit; clr_err_i pulse -> overrun_o=0.
REQ-034 Send 0x55 with stop bit forced 0 -> no byte pushed, frame_err_o=1; next valid 0x41 received correctly after line returns high.
REQ-035 Drive 2000 ns low pulse on ser_rx_i -> back to IDLE, no push, no flags.
REQ-036 Assert rst_ni low during bit 4 of 0x68 -> all outputs 0, FIFO empty; following 0x69 received as 0x69.
REQ-037 FIFO full, rd_ready_i=1 in the stop-bit push cycle -> oldest popped, new byte stored, overrun_o stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    function automatic int unsigned calc_div(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with extra-MSB wrap pointers.
// A push into a full FIFO is accepted only when a pop frees a slot.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;

    // Gated so the read port shows zero whenever nothing is stored
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a FWFT receive FIFO.
// Sticky frame-error and overrun flags, cleared by clr_err_i.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ser_rx_i,
    output logic       rd_valid_o,
    output logic [7:0] rd_data_o,
    input  logic       rd_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       clr_err_i
);

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUDRATE);
    localparam int unsigned HALF = DIV / 2;
    localparam int          CW   = $clog2(DIV + 1);

    // Counter expires on the cycle it reads zero, so load period minus one
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev_q;
    logic          fall;

    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          expired;

    logic          push;
    logic          frame_set;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_drop;
    logic          frame_err_q;
    logic          overrun_q;

    assign rx_s    = sync_q[1];
    assign fall    = rx_prev_q & ~rx_s;
    assign expired = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], ser_rx_i};
            rx_prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fall) begin
                        cnt_q   <= HALF_LD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rx_s) begin
                        cnt_q     <= DIV_LD;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= DIV_LD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (!expired) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stop-bit decision feeds the FIFO directly so the byte shows next cycle
    assign push      = (state_q == STOP) & expired & rx_s;
    assign frame_set = (state_q == STOP) & expired & ~rx_s;

    uart_fifo #(
        .WIDTH(8),
        .DEPTH(int'(FIFO_DEPTH))
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (push),
        .wr_data_i(shift_q),
        .pop_i    (rd_ready_i),
        .rd_data_o(rd_data_o),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .drop_o   (fifo_drop)
    );

    assign rd_valid_o = ~fifo_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~clr_err_i);
            overrun_q   <= fifo_drop | (overrun_q & ~clr_err_i);
        end
    end

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 frames at DIV=217, 40-unit clock.
module tb_uart_rx_fifo;

    localparam int BIT = 8680;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;
    logic       clr_err;

    int n_cmp = 0;
    int n_bad = 0;
    int rises = 0;
    int base;
    logic rv_q;

    always #20 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ  (25_000_000),
        .BAUDRATE  (115200),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ser_rx_i   (ser),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .rd_ready_i (rd_ready),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .clr_err_i  (clr_err)
    );

    always @(posedge clk) begin
        rv_q <= rd_valid;
        if (rd_valid && !rv_q) rises <= rises + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ser = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            ser = b[i];
            #BIT;
        end
        ser = stop_bit;
        #BIT;
        ser = 1'b1;
    endtask

    task automatic read_exp(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, rd_valid, 1);
        chk({tag, "_data"}, rd_data, exp);
        @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ser      = 1'b1;
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        #30;
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single byte 'h'
        base = rises;
        @(negedge clk);
        send_byte(8'h68, 1'b1);
        repeat (4) @(negedge clk);
        chk("h_ferr", frame_err, 0);
        chk("h_ovr", overrun, 0);
        chk("h_rises", rises - base, 1);
        read_exp("h", 8'h68);
        chk("h_empty", rd_valid, 0);

        // five back-to-back bytes overflow a 4-entry FIFO
        @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        chk("ov_before5", overrun, 0);
        send_byte(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        chk("ov_set", overrun, 1);
        chk("ov_ferr", frame_err, 0);
        read_exp("ov0", 8'h00);
        read_exp("ov1", 8'hFF);
        read_exp("ov2", 8'hA5);
        read_exp("ov3", 8'h5A);
        chk("ov_drained", rd_valid, 0);
        pulse_clr();
        chk("ov_clr", overrun, 0);

        // framing error, then recovery
        @(negedge clk);
        send_byte(8'h55, 1'b0);
        chk("fe_set", frame_err, 1);
        chk("fe_nopush", rd_valid, 0);
        #BIT;
        @(negedge clk);
        send_byte(8'h41, 1'b1);
        repeat (4) @(negedge clk);
        read_exp("fe_next", 8'h41);
        chk("fe_sticky", frame_err, 1);
        pulse_clr();
        chk("fe_clr", frame_err, 0);

        // short glitch on the line
        @(negedge clk);
        ser = 1'b0;
        #2000;
        ser = 1'b1;
        #(3 * BIT);
        chk("gl_valid", rd_valid, 0);
        chk("gl_ferr", frame_err, 0);
        chk("gl_ovr", overrun, 0);

        // reset in the middle of a frame with data already queued
        @(negedge clk);
        send_byte(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        chk("mr_pre", rd_valid, 1);
        ser = 1'b0;
        #BIT;
        ser = 1'b0;
        #BIT;
        ser = 1'b0;
        #BIT;
        ser = 1'b0;
        #BIT;
        ser = 1'b1;
        #BIT;
        ser = 1'b0;
        #4000;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", rd_valid, 0);
        chk("mr_data", rd_data, 0);
        chk("mr_ferr", frame_err, 0);
        chk("mr_ovr", overrun, 0);
        ser = 1'b1;
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        #(2 * BIT);
        chk("mr_idle", rd_valid, 0);
        @(negedge clk);
        send_byte(8'h69, 1'b1);
        repeat (4) @(negedge clk);
        read_exp("mr_next", 8'h69);
        chk("mr_empty", rd_valid, 0);

        // full FIFO, pop coincides with the stop-bit push
        @(negedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk);
        chk("pp_head", rd_data, 8'h11);
        @(negedge clk);
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (2063) @(posedge clk);
                #5 rd_ready = 1'b1;
                @(posedge clk);
                #5 rd_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("pp_ovr", overrun, 0);
        read_exp("pp0", 8'h22);
        read_exp("pp1", 8'h33);
        read_exp("pp2", 8'h44);
        read_exp("pp3", 8'h99);
        chk("pp_empty", rd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
